// File: rtl/dmem_responder.sv
// Data-memory responder: one valid/ready request, LATENCY wait states, then a one-cycle response from an internal word RAM.
// Latency: response valid after edge E0+LATENCY (E0 = acceptance edge); one request per LATENCY+2 cycles.
// Backpressure: req_ready is low from acceptance until the response cycle ends; request inputs are ignored while busy.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   req_valid/req_ready      request handshake (req_ready decoded from state only)
//   req_write, req_addr      1 = store / 0 = load, byte address
//   req_wdata, req_be        store data and byte enables
//   resp_valid               one-cycle response strobe
//   resp_rdata, resp_err     load data (0 for stores/errors), misaligned/out-of-range flag
module dmem_responder #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int         DEPTH  = 1 << ADDR_WIDTH;
    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [3:0]              r_cnt;
    logic [3:0]              w_cnt_nxt;
    logic                    w_accept;

    logic                    r_write;
    logic [31:0]             r_addr;
    logic [31:0]             r_wdata;
    logic [3:0]              r_be;

    logic [31:0]             r_rdata;
    logic                    r_err;

    logic [31:0]             r_mem [0:DEPTH-1];

    logic                    w_err;
    logic [ADDR_WIDTH-1:0]   w_idx;
    logic                    w_access;

    // Address checks work on the latched request so the inputs never reach outputs.
    assign w_err    = (r_addr[1:0] != 2'b00) || (r_addr[31:ADDR_WIDTH+2] != '0);
    assign w_idx    = r_addr[ADDR_WIDTH+1:2];
    assign w_access = (r_state == S_BUSY) && (r_cnt == 4'd0);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        req_ready   = 1'b0;
        resp_valid  = 1'b0;
        case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_accept    = 1'b1;
                    w_cnt_nxt   = LAT_M1;
                    w_state_nxt = S_BUSY;
                end
            end
            S_BUSY: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = S_RESP;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            S_RESP: begin
                resp_valid  = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_write <= 1'b0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_be    <= 4'd0;
        end else if (w_accept) begin
            r_write <= req_write;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_be    <= req_be;
        end
    end

    // Response data is captured on the access edge and cleared when leaving RESP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
        end else if (w_access) begin
            r_rdata <= (w_err || r_write) ? 32'd0 : r_mem[w_idx];
            r_err   <= w_err;
        end else if (r_state == S_RESP) begin
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
        end
    end

    // Array is never cleared; reset forces IDLE asynchronously, so a dropped
    // request can never reach the access edge.
    always_ff @(posedge clk) begin
        if (w_access && r_write && !w_err) begin
            for (int i = 0; i < 4; i++) begin
                if (r_be[i]) begin
                    r_mem[w_idx][8*i +: 8] <= r_wdata[8*i +: 8];
                end
            end
        end
    end

    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

    logic        clk;
    logic        rst;
    logic        req_valid  [3];
    logic        req_ready  [3];
    logic        req_write  [3];
    logic [31:0] req_addr   [3];
    logic [31:0] req_wdata  [3];
    logic [3:0]  req_be     [3];
    logic        resp_valid [3];
    logic [31:0] resp_rdata [3];
    logic        resp_err   [3];

    int          errors;
    int          checks;
    int          lat [3];
    logic [31:0] mdl [3][1024];

    dmem_responder #(.ADDR_WIDTH(10), .LATENCY(2)) u_dut_l2 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
        .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]));

    dmem_responder #(.ADDR_WIDTH(10), .LATENCY(1)) u_dut_l1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
        .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]));

    dmem_responder #(.ADDR_WIDTH(10), .LATENCY(5)) u_dut_l5 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[2]), .req_ready(req_ready[2]), .req_write(req_write[2]),
        .req_addr(req_addr[2]), .req_wdata(req_wdata[2]), .req_be(req_be[2]),
        .resp_valid(resp_valid[2]), .resp_rdata(resp_rdata[2]), .resp_err(resp_err[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

    // Reference rules: byte-merge of a store and the address error rule.
    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
        return r;
    endfunction

    function automatic bit addr_err(input logic [31:0] a);
        return (a % 4 != 0) || (a >= 32'd4096);
    endfunction

    // One full transaction on DUT d with timing, data and handshake checks.
    task automatic do_req(input int d, input logic w, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] be,
                          input string tag, output logic [31:0] got);
        bit          e;
        bit          seen;
        logic [31:0] exp;
        e    = addr_err(a);
        exp  = (e || w) ? 32'd0 : mdl[d][a[11:2]];
        seen = 0;
        got  = 32'hx;
        @(negedge clk);
        checks++;
        if (req_ready[d] !== 1'b1) begin
            errors++; $display("FAIL %s ready_idle: got %b want 1", tag, req_ready[d]);
        end
        req_valid[d] = 1'b1; req_write[d] = w; req_addr[d] = a;
        req_wdata[d] = wd;   req_be[d] = be;
        @(posedge clk); #1;
        // Junk while busy must be ignored.
        req_write[d] = 1'($urandom_range(0, 1)); req_addr[d] = $urandom();
        req_wdata[d] = $urandom(); req_be[d] = 4'($urandom_range(0, 15));
        for (int k = 0; k <= lat[d]; k++) begin
            @(negedge clk);
            checks++;
            if (req_ready[d] !== 1'b0) begin
                errors++; $display("FAIL %s ready_busy k=%0d: got %b want 0", tag, k, req_ready[d]);
            end
            if (resp_valid[d] === 1'b1) begin
                checks++;
                if (k != lat[d] || seen) begin
                    errors++; $display("FAIL %s resp_timing: got resp after edge E0+%0d want E0+%0d", tag, k, lat[d]);
                end else begin
                    seen = 1;
                    got  = resp_rdata[d];
                    checks += 2;
                    if (resp_rdata[d] !== exp) begin
                        errors++; $display("FAIL %s rdata: got %h want %h", tag, resp_rdata[d], exp);
                    end
                    if (resp_err[d] !== e) begin
                        errors++; $display("FAIL %s err: got %b want %b", tag, resp_err[d], e);
                    end
                end
            end
            if (k == lat[d]) req_valid[d] = 1'b0;
        end
        checks++;
        if (!seen) begin
            errors++; $display("FAIL %s resp_timeout: got no resp_valid want one at E0+%0d", tag, lat[d]);
        end
        @(negedge clk);
        checks++;
        if (resp_valid[d] !== 1'b0 || req_ready[d] !== 1'b1 || resp_rdata[d] !== 32'd0 || resp_err[d] !== 1'b0) begin
            errors++; $display("FAIL %s post_resp: got valid=%b ready=%b rdata=%h err=%b want 0 1 0 0",
                               tag, resp_valid[d], req_ready[d], resp_rdata[d], resp_err[d]);
        end
        if (w && !e) mdl[d][a[11:2]] = merge(mdl[d][a[11:2]], wd, be);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int d = 0; d < 3; d++) req_valid[d] = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                checks++;
                if (req_ready[d] !== 1'b1 || resp_valid[d] !== 1'b0 || resp_rdata[d] !== 32'd0 || resp_err[d] !== 1'b0) begin
                    errors++; $display("FAIL reset_state d=%0d: got ready=%b valid=%b rdata=%h err=%b want 1 0 0 0",
                                       d, req_ready[d], resp_valid[d], resp_rdata[d], resp_err[d]);
                end
            end
        end
        for (int d = 0; d < 3; d++) req_valid[d] = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_init();
        logic [31:0] g;
        for (int d = 0; d < 3; d++)
            for (int i = 0; i < 32; i++)
                do_req(d, 1'b1, 32'(i * 4), $urandom(), 4'hF, "init", g);
    endtask

    task automatic test_store_load();
        logic [31:0] g;
        do_req(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, "store_10", g);
        do_req(0, 1'b0, 32'h10, 32'h0, 4'h0, "load_10", g);
        checks++;
        if (g !== 32'hDEADBEEF) begin
            errors++; $display("FAIL load_deadbeef: got %h want deadbeef", g);
        end
    endtask

    task automatic test_byte_enables();
        logic [31:0] g;
        do_req(0, 1'b1, 32'h10, 32'h11223344, 4'b0101, "store_be", g);
        do_req(0, 1'b0, 32'h10, 32'h0, 4'h0, "load_be", g);
        checks++;
        if (g !== 32'hDE22BE44) begin
            errors++; $display("FAIL byte_merge: got %h want de22be44", g);
        end
        do_req(0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, "store_be0", g);
        do_req(0, 1'b0, 32'h10, 32'h0, 4'h0, "load_be0", g);
    endtask

    task automatic test_errors();
        logic [31:0] g;
        do_req(0, 1'b0, 32'h13, 32'h0, 4'h0, "load_misaligned", g);
        do_req(0, 1'b1, 32'h1000, 32'h55AA55AA, 4'hF, "store_oor", g);
        do_req(0, 1'b0, 32'h0, 32'h0, 4'h0, "load_word0", g);
    endtask

    // req_valid held every cycle with changing addresses.
    task automatic test_back_to_back(input int d);
        logic [31:0] q[$];
        logic [31:0] a;
        logic [31:0] e;
        int          last_acc;
        int          acc;
        int          ncyc;
        last_acc = -1;
        acc      = 0;
        ncyc     = 3 * (lat[d] + 2);
        for (int c = 0; c < ncyc + lat[d] + 3; c++) begin
            @(negedge clk);
            if (resp_valid[d] === 1'b1) begin
                checks++;
                if (q.size() == 0) begin
                    errors++; $display("FAIL b2b_extra_resp d=%0d: got rdata %h want no response", d, resp_rdata[d]);
                end else begin
                    e = mdl[d][q.pop_front() >> 2];
                    if (resp_rdata[d] !== e) begin
                        errors++; $display("FAIL b2b_rdata d=%0d: got %h want %h", d, resp_rdata[d], e);
                    end
                end
            end
            if (c < ncyc) begin
                a = 32'(32'h40 + 4 * (c % 3));
                req_valid[d] = 1'b1; req_write[d] = 1'b0; req_addr[d] = a;
                if (req_ready[d] === 1'b1) begin
                    if (last_acc >= 0) begin
                        checks++;
                        if (c - last_acc != lat[d] + 2) begin
                            errors++; $display("FAIL b2b_spacing d=%0d: got %0d cycles want %0d", d, c - last_acc, lat[d] + 2);
                        end
                    end
                    last_acc = c;
                    acc++;
                    q.push_back(a);
                end
            end else begin
                req_valid[d] = 1'b0;
            end
        end
        checks += 2;
        if (acc != 3) begin
            errors++; $display("FAIL b2b_count d=%0d: got %0d acceptances want 3", d, acc);
        end
        if (q.size() != 0) begin
            errors++; $display("FAIL b2b_missing_resp d=%0d: got %0d outstanding want 0", d, q.size());
        end
    endtask

    task automatic test_reset_mid_busy();
        logic [31:0] g;
        @(negedge clk);
        req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 32'h20;
        req_wdata[0] = 32'hCAFEF00D; req_be[0] = 4'hF;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < lat[0] + 3; k++) begin
            @(negedge clk);
            checks++;
            if (resp_valid[0] !== 1'b0) begin
                errors++; $display("FAIL rst_busy_resp k=%0d: got resp_valid %b want 0", k, resp_valid[0]);
            end
        end
        do_req(0, 1'b0, 32'h20, 32'h0, 4'h0, "rst_busy_readback", g);
    endtask

    task automatic test_reset_in_resp();
        logic [31:0] g;
        logic [31:0] wd;
        bit          seen;
        wd   = $urandom();
        seen = 0;
        @(negedge clk);
        req_valid[2] = 1'b1; req_write[2] = 1'b1; req_addr[2] = 32'h24;
        req_wdata[2] = wd; req_be[2] = 4'hF;
        @(posedge clk); #1;
        req_valid[2] = 1'b0;
        for (int k = 0; k < 12 && !seen; k++) begin
            @(negedge clk);
            if (resp_valid[2] === 1'b1) seen = 1;
        end
        checks++;
        if (!seen) begin
            errors++; $display("FAIL rst_resp_timeout: got no resp_valid want one");
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if (resp_valid[2] !== 1'b0) begin
            errors++; $display("FAIL rst_resp_async: got resp_valid %b want 0", resp_valid[2]);
        end
        mdl[2][9] = wd;
        @(negedge clk);
        rst = 1'b0;
        do_req(2, 1'b0, 32'h24, 32'h0, 4'h0, "rst_resp_readback", g);
    endtask

    task automatic test_random(input int n);
        logic [31:0] g;
        logic [31:0] a;
        logic [3:0]  be;
        logic        w;
        int          d;
        int          kind;
        for (int i = 0; i < n; i++) begin
            d    = $urandom_range(0, 2);
            kind = $urandom_range(0, 9);
            w    = 1'($urandom_range(0, 1));
            be   = 4'($urandom_range(0, 15));
            a    = 32'($urandom_range(0, 31) * 4);
            if (kind == 7) a = a | 32'($urandom_range(1, 3));
            if (kind == 8) a = $urandom() | 32'h1000;
            if (kind == 9) begin w = 1'b1; be = 4'h0; end
            do_req(d, w, a, $urandom(), be, "random", g);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        lat[0] = 2; lat[1] = 1; lat[2] = 5;
        rst = 1'b1;
        for (int d = 0; d < 3; d++) begin
            req_valid[d] = 1'b0; req_write[d] = 1'b0; req_addr[d] = 32'd0;
            req_wdata[d] = 32'd0; req_be[d] = 4'd0;
        end
        test_reset();
        test_init();
        test_store_load();
        test_byte_enables();
        test_errors();
        test_back_to_back(0);
        test_back_to_back(1);
        test_back_to_back(2);
        test_reset_mid_busy();
        test_reset_in_resp();
        test_random(60);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
